// File: rtl/somador_pipe_pkg.sv
// Shared helpers for the pipelined adder: slice width, parameter legality, per-slice payload width.
package somador_pipe_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (width > 0) && ((width % ((stages < 1) ? 1 : stages)) == 0);
  endfunction

  function automatic int calc_sl(input int width, input int stages);
    return width / ((stages < 1) ? 1 : stages);
  endfunction

  // Payload entering slice k: finished sum bits below k plus interleaved {b,a} slices from k upward.
  function automatic int pay_w(input int width, input int sl, input int k);
    return 2 * width - k * sl;
  endfunction

endpackage

// File: rtl/somador_pipe_slice.sv
// One SL-bit adder slice with its valid/payload/carry registers and ready term; latency 1,
// loads whenever it is empty or the next slice is ready.
module somador_pipe_slice
  import somador_pipe_pkg::*;
#(
  parameter int SL    = 4,
  parameter int PAY_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_in,
  input  logic               c_in,
  input  logic [PAY_W-1:0]   pay_in,
  input  logic               rdy_nxt,
  output logic               rdy_out,
  output logic               v_out,
  output logic               c_out,
  output logic [PAY_W-SL-1:0] pay_out
);

  typedef struct packed {
    logic                v;
    logic                carry;
    logic [PAY_W-SL-1:0] pay;
  } slice_state_t;

  slice_state_t        st_q, st_d;
  logic [SL:0]         add;
  logic [PAY_W-SL-1:0] nxt_pay;

  assign add = {1'b0, pay_in[SL-1:0]} + {1'b0, pay_in[2*SL-1:SL]} + {{SL{1'b0}}, c_in};

  // New sum slice lands on top of the lower sums; remaining operand slices shift down by one slot.
  if (PAY_W == 2 * SL) begin : g_only
    assign nxt_pay = add[SL-1:0];
  end else begin : g_fwd
    assign nxt_pay = {add[SL-1:0], pay_in[PAY_W-1:2*SL]};
  end

  assign rdy_out = !st_q.v || rdy_nxt;

  always_comb begin
    st_d = st_q;
    if (rdy_out) begin
      st_d.v = v_in;
      if (v_in) begin
        st_d.carry = add[SL];
        st_d.pay   = nxt_pay;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign v_out   = st_q.v;
  assign c_out   = st_q.carry;
  assign pay_out = st_q.pay;

endmodule

// File: rtl/somador_pipe_param.sv
// WIDTH-bit adder, carry chain cut into STAGES registered slices; latency STAGES, 1 result/cycle,
// ack_out is a combinational ready chain from ack_in. SOMADOR_PIPE_SAT_EN clamps on carry out.
module somador_pipe_param
  import somador_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ack_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] soma_saida,
  output logic             cout,
  input  logic             ack_in
);

  localparam int SL = calc_sl(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_param_err
    $error("somador_pipe_param: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic [2*WIDTH-1:0] pay_first;
  logic [STAGES-1:0]  v;
  logic [STAGES-1:0]  carry;
  logic [STAGES:0]    rdy;
  logic [WIDTH-1:0]   sum_raw;

  // Interleave operand slices so each stage finds its {b,a} pair in the lowest 2*SL bits.
  always_comb begin
    pay_first = '0;
    for (int k = 0; k < STAGES; k++) begin
      pay_first[2*k*SL +: SL]     = a[k*SL +: SL];
      pay_first[(2*k+1)*SL +: SL] = b[k*SL +: SL];
    end
  end

  assign rdy[STAGES] = ack_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    localparam int PW = pay_w(WIDTH, SL, k);

    logic              v_prev;
    logic              c_prev;
    logic [PW-1:0]     pay_prev;
    logic [PW-SL-1:0]  pay_o;

    if (k == 0) begin : g_head
      assign v_prev   = in_valid;
      assign c_prev   = cin;
      assign pay_prev = pay_first;
    end else begin : g_body
      assign v_prev   = v[k-1];
      assign c_prev   = carry[k-1];
      assign pay_prev = g_slice[k-1].pay_o;
    end

    if (k == STAGES - 1) begin : g_tail
      assign sum_raw = pay_o;
    end

    somador_pipe_slice #(
      .SL    (SL),
      .PAY_W (PW)
    ) u_slice (
      .clk     (clk),
      .rst     (reset),
      .v_in    (v_prev),
      .c_in    (c_prev),
      .pay_in  (pay_prev),
      .rdy_nxt (rdy[k+1]),
      .rdy_out (rdy[k]),
      .v_out   (v[k]),
      .c_out   (carry[k]),
      .pay_out (pay_o)
    );
  end

  assign ack_out   = rdy[0] && !reset;
  assign out_valid = v[STAGES-1];
  assign cout      = carry[STAGES-1];

`ifdef SOMADOR_PIPE_SAT_EN
  assign soma_saida = cout ? {WIDTH{1'b1}} : sum_raw;
`else
  assign soma_saida = sum_raw;
`endif

endmodule
